// File: rtl/passcode_encoder.sv
// Passcode encoder: maps a decimal digit to a 5-bit code, latches it on code_out
// and sends it MSB first on ser_out, each bit held for BIT_CYCLES clocks.
module passcode_encoder #(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic [4:0] code_out,
  output logic       ser_out,
  output logic       ser_frame,
  output logic       tx_done,
  output logic       err,
  output logic [3:0] digit_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_T    = 4'(BIT_CYCLES - 1);
  localparam logic [3:0] PRE_T     = 4'(BIT_CYCLES - 2);
  localparam bit         ONE_CYCLE = (BIT_CYCLES == 1);

  function automatic logic [4:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 5'b00000;
      4'd1:    encode = 5'b00001;
      4'd2:    encode = 5'b10001;
      4'd3:    encode = 5'b10010;
      4'd4:    encode = 5'b01010;
      4'd5:    encode = 5'b01011;
      4'd6:    encode = 5'b11011;
      4'd7:    encode = 5'b11111;
      4'd8:    encode = 5'b01111;
      4'd9:    encode = 5'b01110;
      default: encode = 5'b00000;
    endcase
  endfunction

  state_t     state;
  logic [4:0] shreg;
  logic [2:0] bit_idx;
  logic [3:0] bit_tmr;
  logic [4:0] enc_code;
  logic       legal;

  assign enc_code    = encode(digit_in);
  assign legal       = (digit_in <= 4'd9);
  assign digit_ready = (state == IDLE);
  // The shift register is cleared at frame end, so its MSB is already 0 in IDLE.
  assign ser_out     = shreg[4];

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values into later lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      code_out    <= '0;
      bit_idx     <= '0;
      bit_tmr     <= '0;
      ser_frame   <= 1'b0;
      tx_done     <= 1'b0;
      err         <= 1'b0;
      digit_count <= '0;
    end else begin
      err     <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (digit_valid) begin
            if (legal) begin
              shreg     <= enc_code;
              code_out  <= enc_code;
              bit_idx   <= 3'd4;
              bit_tmr   <= '0;
              ser_frame <= 1'b1;
              state     <= SHIFT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bit_tmr == LAST_T) begin
            bit_tmr <= '0;
            if (bit_idx == 3'd0) begin
              state     <= IDLE;
              ser_frame <= 1'b0;
              shreg     <= '0;
              if (digit_count != 4'd15) digit_count <= digit_count + 4'd1;
            end else begin
              bit_idx <= bit_idx - 3'd1;
              shreg   <= {shreg[3:0], 1'b0};
              // With one-cycle bits the last bit is also its own final cycle.
              tx_done <= ONE_CYCLE && (bit_idx == 3'd1);
            end
          end else begin
            bit_tmr <= bit_tmr + 4'd1;
            tx_done <= !ONE_CYCLE && (bit_idx == 3'd0) && (bit_tmr == PRE_T);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_passcode_encoder.sv
// Bench for passcode_encoder: two instances (BIT_CYCLES 1 and 3) share stimulus and
// are compared every cycle against a frame-level model, plus literal spot checks.
module tb_passcode_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       digit_valid;

  logic       rdy  [2];
  logic [4:0] code [2];
  logic       ser  [2];
  logic       frm  [2];
  logic       txd  [2];
  logic       er   [2];
  logic [3:0] cnt  [2];

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  passcode_encoder #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(rdy[0]), .code_out(code[0]), .ser_out(ser[0]), .ser_frame(frm[0]),
    .tx_done(txd[0]), .err(er[0]), .digit_count(cnt[0])
  );

  passcode_encoder #(.BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(rdy[1]), .code_out(code[1]), .ser_out(ser[1]), .ser_frame(frm[1]),
    .tx_done(txd[1]), .err(er[1]), .digit_count(cnt[1])
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Frame-level model: a frame is just "rem" cycles left of a known code.
  logic [4:0] enc [10] = '{5'b00000, 5'b00001, 5'b10001, 5'b10010, 5'b01010,
                           5'b01011, 5'b11011, 5'b11111, 5'b01111, 5'b01110};
  int         bc   [2] = '{1, 3};
  int         rem  [2];
  logic [4:0] mcode[2];
  int         mcnt [2];
  bit         merr [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        rem[d] = 0; mcode[d] = '0; mcnt[d] = 0; merr[d] = 1'b0;
      end else begin
        merr[d] = 1'b0;
        if (rem[d] > 0) begin
          rem[d]--;
          if (rem[d] == 0 && mcnt[d] < 15) mcnt[d]++;
        end else if (digit_valid) begin
          if (digit_in > 4'd9) merr[d] = 1'b1;
          else begin
            mcode[d] = enc[digit_in];
            rem[d]   = 5 * bc[d];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int         el;
        int         idx;
        logic [4:0] c;
        bit         exp_ser;
        el  = 5 * bc[d] - rem[d];
        idx = 4 - el / bc[d];
        c   = mcode[d];
        exp_ser = (rem[d] > 0) ? c[idx] : 1'b0;
        check($sformatf("bc%0d digit_ready", bc[d]), rdy[d], rem[d] == 0);
        check($sformatf("bc%0d ser_frame", bc[d]), frm[d], rem[d] > 0);
        check($sformatf("bc%0d ser_out", bc[d]), ser[d], exp_ser);
        check($sformatf("bc%0d tx_done", bc[d]), txd[d], rem[d] == 1);
        check($sformatf("bc%0d err", bc[d]), er[d], merr[d]);
        check($sformatf("bc%0d code_out", bc[d]), code[d], mcode[d]);
        check($sformatf("bc%0d digit_count", bc[d]), cnt[d], mcnt[d]);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(rdy[0] && rdy[1]) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("wait_idle in budget", n < 200, 1);
  endtask

  task automatic send(input logic [3:0] d);
    wait_idle();
    digit_in    = d;
    digit_valid = 1'b1;
    @(posedge clk); #2;
    digit_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  b1;
    logic [4:0]  t1;
    logic [15:0] b3;
    int          f3;
    int          k;
    int          cyc;
    int          last;
    bit          r;

    rst_n       = 1'b0;
    digit_valid = 1'b1;
    digit_in    = 4'd5;
    @(posedge clk); #2;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset code_out", code[0], 0);
    check("reset digit_count", cnt[0], 0);
    check("reset ready", rdy[0], 1);
    check("reset frame", frm[1], 0);
    rst_n       = 1'b1;
    digit_valid = 1'b0;

    // Digit 6 on BIT_CYCLES=1.
    send(4'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b1[4-i] = ser[0];
      t1[4-i] = txd[0];
    end
    check("send6 serial bits", b1, 5'b11011);
    check("send6 tx_done pos", t1, 5'b00001);
    check("send6 code_out", code[0], 5'b11011);
    @(negedge clk);
    check("send6 digit_count", cnt[0], 1);

    // Digit 2 on BIT_CYCLES=3.
    send(4'd2);
    b3 = '0;
    f3 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b3 = {b3[14:0], ser[1]};
      f3 += int'(frm[1]);
    end
    check("send2 bc3 serial bits", b3, 16'b1110_0000_0000_1110);
    check("send2 bc3 frame length", f3, 15);

    // Illegal digit then 9.
    send(4'd12);
    @(negedge clk);
    check("illegal err bc1", er[0], 1);
    check("illegal err bc3", er[1], 1);
    check("illegal no frame", frm[0], 0);
    @(negedge clk);
    check("illegal err drops", er[0], 0);
    check("illegal code kept", code[0], 5'b10001);
    check("illegal count kept", cnt[0], 2);
    send(4'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b1[4-i] = ser[0];
    end
    check("send9 serial bits", b1, 5'b01110);
    check("send9 code_out", code[0], 5'b01110);

    // Stream 0..9 with digit_valid held high.
    wait_idle();
    do_reset();
    digit_in    = 4'd0;
    digit_valid = 1'b1;
    k = 0; cyc = 0; last = 0;
    while (k < 10 && cyc < 300) begin
      r = rdy[0];
      @(posedge clk); #2;
      cyc++;
      if (r) begin
        if (k > 0) check("stream frame spacing", cyc - last, 6);
        last = cyc;
        k++;
        if (k < 10) digit_in = 4'(k);
      end
    end
    digit_valid = 1'b0;
    check("stream transfers", k, 10);
    wait_idle();
    @(negedge clk);
    check("stream digit_count", cnt[0], 10);

    // Reset during cycle 3 of a 7 frame.
    do_reset();
    send(4'd7);
    repeat (2) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("abort ser_frame", frm[0], 0);
    check("abort ser_out", ser[0], 0);
    check("abort tx_done", txd[0], 0);
    check("abort code_out", code[0], 0);
    check("abort digit_count", cnt[0], 0);
    rst_n = 1'b1;
    #1;
    check("abort ready", rdy[0], 1);
    send(4'd0);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b1[4-i] = ser[0];
      k += int'(frm[0]);
    end
    check("send0 serial bits", b1, 5'b00000);
    check("send0 frame length", k, 5);

    // Saturation: seventeen more legal digits.
    repeat (17) send(4'($urandom_range(0, 9)));
    wait_idle();
    @(negedge clk);
    check("saturate bc1", cnt[0], 15);
    check("saturate bc3", cnt[1], 15);

    // Random traffic with occasional resets.
    repeat (1500) begin
      @(posedge clk); #2;
      digit_valid = ($urandom_range(0, 9) < 6);
      digit_in    = 4'($urandom_range(0, 15));
      rst_n       = ($urandom_range(0, 199) != 0);
    end
    rst_n       = 1'b1;
    digit_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/passcode_encoder.md
PASSCODE_ENCODER -- requirements
Module: passcode_encoder

Interface
REQ-001 Parameter: BIT_CYCLES, default 1, clock cycles each serial bit is held (legal 1..16).
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: digit_in  input  4  decimal digit to encode (0..9 legal).
REQ-006 Port: digit_valid  input  1  digit_in is offered this cycle.
REQ-007 Port: digit_ready  output  1  block accepts a digit this cycle.
REQ-008 Port: code_out  output  5  encoded code of the last accepted legal digit.
REQ-009 Port: ser_out  output  1  serial code bit, MSB first.
REQ-010 Port: ser_frame  output  1  high while ser_out carries a code bit.
REQ-011 Port: tx_done  output  1  one-cycle pulse on the final cycle of a frame.
REQ-012 Port: err  output  1  one-cycle pulse when an illegal digit (10..15) is offered.
REQ-013 Port: digit_count  output  4  legal digits transmitted since reset, saturating at 15.

Function
REQ-014 Encoding SHALL be: 0->00000, 1->00001, 2->10001, 3->10010, 4->01010, 5->01011, 6->11011, 7->11111, 8->01111, 9->01110.
REQ-015 FSM SHALL have two states: IDLE and SHIFT.
REQ-016 digit_ready SHALL be high in IDLE and low in SHIFT.
REQ-017 Handshake: transfer occurs on a rising edge with digit_valid=1 and digit_ready=1; no other edge captures digit_in.
REQ-018 Legal transfer: code latched into shift register and code_out; state -> SHIFT; bit index = 4; bit timer = 0.
REQ-019 Illegal transfer (digit_in>9): err=1 for exactly the next cycle; state stays IDLE; code_out, digit_count unchanged; no frame.
REQ-020 In SHIFT: ser_frame=1; ser_out = shift-register bit at current index (bit 4 first, bit 0 last).
REQ-021 Each bit held exactly BIT_CYCLES cycles; frame length = 5*BIT_CYCLES cycles, starting the cycle after transfer.
REQ-022 tx_done=1 on the last cycle of bit 0 only; on that edge state -> IDLE, digit_count increments (saturate at 15).
REQ-023 Earliest next transfer: the cycle after tx_done (digit_ready high); back-to-back frames separated by exactly one IDLE cycle.
REQ-024 In IDLE: ser_out=0, ser_frame=0, tx_done=0.
REQ-025 digit_in/digit_valid changes during SHIFT SHALL not affect the frame in progress.
REQ-026 Latency: first code bit on ser_out one cycle after the transfer edge.

Reset
REQ-027 With rst_n=0 at a rising edge: state=IDLE, code_out=00000, shift register=00000, ser_out=0, ser_frame=0, tx_done=0, err=0, digit_count=0, timers cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no tx_done and no count increment; digit_ready=1 the first cycle after reset releases.
REQ-029 digit_valid during reset SHALL be ignored.

Verification
REQ-030 BIT_CYCLES=1, send 6 -> code_out=11011; ser_out 1,1,0,1,1 on cycles 1..5; tx_done on cycle 5; digit_count=1.
REQ-031 BIT_CYCLES=3, send 2 -> ser_out 1,1,1,0,0,0,0,0,0,0,0,0,1,1,1 over 15 cycles; ser_frame high exactly 15 cycles.
REQ-032 Send 12 -> err pulse 1 cycle, no ser_frame, code_out and digit_count unchanged; then send 9 -> 01110 transmitted.
REQ-033 digit_valid held high with 0..9 streamed -> all ten frames in order, one IDLE cycle between frames, digit_count=10.
REQ-034 Reset at cycle 3 of a frame sending 7 -> outputs at reset values, digit_count=0, no tx_done; next send 0 -> 00000 frame.
REQ-035 Seventeen legal digits -> digit_count saturates at 15.
